inference: RTL and testbench

//  Multinomial logistic-regression classifier core for 28x28 (784-pixel) digit images.
//  For each of 10 classes it computes score = bias + sum(w*x) over all 784 pixels.
//  It then outputs the argmax class. It sits between the weight/bias ROMs, the input image
//  RAM and the result/display logic. All memories have a 1-cycle synchronous read.

---
 rtl/inference.sv | 149 ++++++++++++++
 tb/tb_inference.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inference.sv
// Logistic-regression digit classifier: score = bias + sum(w*x) per class, then argmax over classes.
// 788 cycles per class (done pulse 7881 cycles after the start edge); start ignored while busy or weights not ready.

module inference #(
  parameter int NUM_PIXELS  = 784,
  parameter int NUM_CLASSES = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic [12:0]        weight_addr,
  input  logic signed [7:0]  weight_data,
  output logic [3:0]         bias_addr,
  input  logic signed [31:0] bias_data,
  output logic [9:0]         input_addr,
  input  logic [7:0]         input_pixel,
  input  logic               weights_ready,
  input  logic               start_inference,
  output logic [3:0]         predicted_digit,
  output logic               inference_done,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_BIAS  = 3'd1,
    COMPUTE    = 3'd2,
    ADD_BIAS   = 3'd3,
    COMPARE    = 3'd4,
    NEXT_CLASS = 3'd5,
    DONE       = 3'd6
  } state_t;

  localparam logic [9:0] LAST_PIXEL = 10'(NUM_PIXELS - 1);
  localparam logic [3:0] LAST_CLASS = 4'(NUM_CLASSES - 1);

  state_t             state_q;
  logic [3:0]         class_q;
  logic [9:0]         cur_pix_q;
  logic signed [7:0]  weight_reg_q;
  logic [7:0]         pixel_reg_q;
  logic               addr_vld_q;
  logic               stage_vld_q;
  logic signed [31:0] acc_q;
  logic signed [31:0] max_score_q;
  logic [3:0]         best_class_q;
  logic [3:0]         predicted_q;
  logic               done_q;

  logic signed [16:0] mult_d;
  logic signed [31:0] product_d;
  logic signed [31:0] score_d;

  assign mult_d    = 17'(weight_reg_q) * 17'($signed({1'b0, pixel_reg_q}));
  assign product_d = 32'(mult_d);
  assign score_d   = acc_q + bias_data;

  // Addresses follow the counters, so they hold their last value outside COMPUTE.
  assign weight_addr     = 13'(class_q) * 13'(NUM_PIXELS) + 13'(cur_pix_q);
  assign bias_addr       = class_q;
  assign input_addr      = cur_pix_q;
  assign predicted_digit = predicted_q;
  assign inference_done  = done_q;
  assign busy            = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      class_q      <= '0;
      cur_pix_q    <= '0;
      weight_reg_q <= '0;
      pixel_reg_q  <= '0;
      addr_vld_q   <= 1'b0;
      stage_vld_q  <= 1'b0;
      acc_q        <= '0;
      max_score_q  <= '0;
      best_class_q <= '0;
      predicted_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      // Memory data lags its address by one cycle; the MAC lags the capture by one more.
      addr_vld_q  <= (state_q == COMPUTE);
      stage_vld_q <= addr_vld_q;
      if (addr_vld_q) begin
        weight_reg_q <= weight_data;
        pixel_reg_q  <= input_pixel;
      end
      if (stage_vld_q) begin
        acc_q <= acc_q + product_d;
      end

      case (state_q)
        IDLE: begin
          if (start_inference && weights_ready) begin
            class_q      <= '0;
            max_score_q  <= 32'sh8000_0000;
            acc_q        <= '0;
            weight_reg_q <= '0;
            pixel_reg_q  <= '0;
            addr_vld_q   <= 1'b0;
            stage_vld_q  <= 1'b0;
            state_q      <= LOAD_BIAS;
          end
        end
        LOAD_BIAS: begin
          cur_pix_q   <= '0;
          acc_q       <= '0;
          addr_vld_q  <= 1'b0;
          stage_vld_q <= 1'b0;
          state_q     <= COMPUTE;
        end
        COMPUTE: begin
          if (cur_pix_q == LAST_PIXEL) begin
            state_q <= ADD_BIAS;
          end else begin
            cur_pix_q <= cur_pix_q + 10'd1;
          end
        end
        ADD_BIAS: state_q <= COMPARE;
        COMPARE:  state_q <= NEXT_CLASS;
        NEXT_CLASS: begin
          // Strict greater-than: ties keep the lower class index.
          if (class_q == 4'd0 || score_d > max_score_q) begin
            max_score_q  <= score_d;
            best_class_q <= class_q;
          end
          acc_q        <= '0;
          weight_reg_q <= '0;
          pixel_reg_q  <= '0;
          addr_vld_q   <= 1'b0;
          stage_vld_q  <= 1'b0;
          if (class_q == LAST_CLASS) begin
            state_q <= DONE;
          end else begin
            class_q <= class_q + 4'd1;
            state_q <= LOAD_BIAS;
          end
        end
        DONE: begin
          predicted_q <= best_class_q;
          done_q      <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inference.sv
// Bench for inference: directed and random images scored against a loop-based argmax model.
module tb_inference;

  logic               clk = 1'b0;
  logic               rst;
  logic [12:0]        weight_addr;
  logic signed [7:0]  weight_data;
  logic [3:0]         bias_addr;
  logic signed [31:0] bias_data;
  logic [9:0]         input_addr;
  logic [7:0]         input_pixel;
  logic               weights_ready;
  logic               start_inference;
  logic [3:0]         predicted_digit;
  logic               inference_done;
  logic               busy;

  always #5 clk = ~clk;

  inference dut (
    .clk             (clk),
    .rst             (rst),
    .weight_addr     (weight_addr),
    .weight_data     (weight_data),
    .bias_addr       (bias_addr),
    .bias_data       (bias_data),
    .input_addr      (input_addr),
    .input_pixel     (input_pixel),
    .weights_ready   (weights_ready),
    .start_inference (start_inference),
    .predicted_digit (predicted_digit),
    .inference_done  (inference_done),
    .busy            (busy)
  );

  logic signed [7:0]  wmem [0:7839];
  logic signed [31:0] bmem [0:9];
  logic [7:0]         imem [0:783];

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    weight_data <= wmem[weight_addr];
    bias_data   <= bmem[bias_addr];
    input_pixel <= imem[input_addr];
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: direct sum over every pixel per class, argmax with strict compare.
  task automatic ref_model(output int best, output int best_score);
    int s;
    best = 0;
    best_score = 0;
    for (int c = 0; c < 10; c++) begin
      s = bmem[c];
      for (int p = 0; p < 784; p++)
        s += int'(wmem[c*784 + p]) * int'(imem[p]);
      if (c == 0 || s > best_score) begin
        best = c;
        best_score = s;
      end
    end
  endtask

  // Per-class observation of the sweep: address sequence, cycle count, clean entry state.
  logic [2:0] prev_st;
  logic [2:0] cur_st;
  int mon_cls, mon_pix, mon_cnt, mon_bad;

  always @(negedge clk) begin
    if (inference_done === 1'b1) done_cnt++;
    if (rst !== 1'b1) begin
      prev_st = 3'd0;
    end else begin
      cur_st = dut.state_q;
      if (cur_st == 3'd1 && prev_st != 3'd1) begin
        mon_cls = (prev_st == 3'd0) ? 0 : mon_cls + 1;
        mon_pix = 0;
        mon_cnt = 0;
        mon_bad = 0;
        chk("lb_weight_reg", 32'(dut.weight_reg_q), 32'd0);
        chk("lb_pixel_reg",  32'(dut.pixel_reg_q), 32'd0);
        chk("lb_product",    32'(dut.product_d), 32'd0);
        chk("lb_accum",      32'(dut.acc_q), 32'd0);
        chk("lb_bias_addr",  32'(bias_addr), 32'(mon_cls));
      end
      if (cur_st == 3'd2) begin
        if (32'(input_addr) != 32'(mon_pix) ||
            32'(weight_addr) != 32'(mon_cls * 784 + mon_pix)) mon_bad++;
        mon_pix++;
        mon_cnt++;
      end
      if (cur_st == 3'd3 && prev_st != 3'd3) begin
        chk("ab_cur_pixel", 32'(dut.cur_pix_q), 32'd783);
        chk("compute_cycles", 32'(mon_cnt), 32'd784);
        chk("addr_sequence_errs", 32'(mon_bad), 32'd0);
      end
      prev_st = cur_st;
    end
  end

  task automatic run(input string tag, output logic [3:0] pd);
    int n;
    int exp_best, exp_score;
    bit seen;
    ref_model(exp_best, exp_score);
    @(negedge clk);
    start_inference = 1'b1;
    @(posedge clk);
    #1 start_inference = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 9000 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 100) start_inference = 1'b1;
      if (n == 101) start_inference = 1'b0;
      if (inference_done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'd7881);
    chk({tag, "_predicted"}, 32'(predicted_digit), 32'(exp_best));
    chk({tag, "_max_score"}, 32'(dut.max_score_q), 32'(exp_score));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    pd = predicted_digit;
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, 32'(inference_done), 32'd0);
    chk({tag, "_pred_hold"}, 32'(predicted_digit), 32'(exp_best));
  endtask

  task automatic fill(input int wval, input int pval, input int bval);
    for (int i = 0; i < 7840; i++) wmem[i] = 8'(wval);
    for (int i = 0; i < 784; i++)  imem[i] = 8'(pval);
    for (int i = 0; i < 10; i++)   bmem[i] = 32'(bval);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 7840; i++) wmem[i] = 8'($urandom);
    for (int i = 0; i < 784; i++)  imem[i] = 8'($urandom);
    for (int i = 0; i < 10; i++)   bmem[i] = 32'(int'($urandom_range(0, 2000000)) - 1000000);
  endtask

  logic [3:0] pd_a, pd_b;
  int n_wait, dc_before;
  logic [2:0] st_now;

  initial begin
    rst = 1'b0;
    start_inference = 1'b0;
    weights_ready = 1'b1;
    fill(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_predicted", 32'(predicted_digit), 32'd0);
    chk("reset_done", 32'(inference_done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;

    // Start ignored while weights are not ready.
    weights_ready = 1'b0;
    @(negedge clk) start_inference = 1'b1;
    repeat (3) @(posedge clk);
    #1 start_inference = 1'b0;
    chk("not_ready_busy", 32'(busy), 32'd0);
    weights_ready = 1'b1;

    fill(0, 0, 0);
    for (int c = 0; c < 10; c++) bmem[c] = 32'(1000 * c);
    run("bias_only", pd_a);
    chk("bias_only_const", 32'(pd_a), 32'd9);

    fill(0, 1, 0);
    for (int p = 0; p < 784; p++) wmem[3*784 + p] = 8'sd1;
    run("class3", pd_a);
    chk("class3_const", 32'(pd_a), 32'd3);
    chk("class3_score", 32'(dut.max_score_q), 32'd784);

    fill(-1, 255, -1);
    bmem[7] = 32'sd0;
    run("neg_weights", pd_a);
    chk("neg_weights_const", 32'(pd_a), 32'd7);

    fill(0, 0, 0);
    run("all_tie", pd_a);
    chk("all_tie_const", 32'(pd_a), 32'd0);

    fill_random();
    run("rand1", pd_a);

    fill_random();
    run("rand2", pd_a);

    // Abort mid-COMPUTE of class 4, then rerun the same data.
    dc_before = done_cnt;
    @(negedge clk) start_inference = 1'b1;
    @(posedge clk);
    #1 start_inference = 1'b0;
    n_wait = 0;
    st_now = dut.state_q;
    while (n_wait < 5000 && !(st_now == 3'd2 && bias_addr == 4'd4)) begin
      @(posedge clk);
      #1;
      n_wait++;
      st_now = dut.state_q;
    end
    chk("abort_reached_class4", 32'(n_wait < 5000), 32'd1);
    repeat (50) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_state", 32'(dut.state_q), 32'd0);
    chk("abort_predicted", 32'(predicted_digit), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - dc_before), 32'd0);
    run("after_abort", pd_b);
    chk("abort_same_result", 32'(pd_b), 32'(pd_a));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
